// File: rtl/mesi_isc_breq_fifos_n.sv
`default_nettype none
// ============================================================================
// Module      : mesi_isc_breq_fifos_n
// Description : Broadcast-request queue stage for the MESI ISC. Write- and
//               read-broadcast commands from NUM_CPUS bus masters are queued
//               in per-CPU FIFOs, tagged with a shared broadcast ID, and
//               drained by a round-robin arbiter into the broadcast FIFO.
// Ports       : clk, rst_n                 clock, synchronous active-low reset
//               mbus_cmd_array_i           per-CPU command (slice k = CPU k)
//               mbus_addr_array_i          per-CPU address
//               broad_fifo_status_full_i   downstream broadcast FIFO full
//               mbus_ack_array_o           registered one-cycle ack per CPU
//               broad_fifo_wr_o            broadcast FIFO write strobe
//               broad_addr_o/type_o/cpu_id_o/id_o  granted FIFO head
//               fifo_count_array_o         per-CPU FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module mesi_isc_breq_fifos_n #(
   parameter int NUM_CPUS         = 4,
   parameter int MBUS_CMD_WIDTH   = 3,
   parameter int ADDR_WIDTH       = 32,
   parameter int BROAD_TYPE_WIDTH = 2,
   parameter int BROAD_ID_WIDTH   = 7,
   parameter int FIFO_DEPTH       = 2,
   localparam int CPU_ID_WIDTH    = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1,
   localparam int CNT_WIDTH       = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_CPUS*MBUS_CMD_WIDTH-1:0] mbus_cmd_array_i,
   input  logic [NUM_CPUS*ADDR_WIDTH-1:0] mbus_addr_array_i,
   input  logic                           broad_fifo_status_full_i,
   output logic [NUM_CPUS-1:0]            mbus_ack_array_o,
   output logic                           broad_fifo_wr_o,
   output logic [ADDR_WIDTH-1:0]          broad_addr_o,
   output logic [BROAD_TYPE_WIDTH-1:0]    broad_type_o,
   output logic [CPU_ID_WIDTH-1:0]        broad_cpu_id_o,
   output logic [BROAD_ID_WIDTH-1:0]      broad_id_o,
   output logic [NUM_CPUS*CNT_WIDTH-1:0]  fifo_count_array_o
);

   localparam int PTR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   localparam logic [MBUS_CMD_WIDTH-1:0]   c_CMD_WR_BROAD = MBUS_CMD_WIDTH'(3);
   localparam logic [MBUS_CMD_WIDTH-1:0]   c_CMD_RD_BROAD = MBUS_CMD_WIDTH'(4);
   localparam logic [BROAD_TYPE_WIDTH-1:0] c_TYPE_WR      = BROAD_TYPE_WIDTH'(1);
   localparam logic [BROAD_TYPE_WIDTH-1:0] c_TYPE_RD      = BROAD_TYPE_WIDTH'(2);

   // Registered state
   logic [NUM_CPUS-1:0]         ack_q;
   logic [BROAD_ID_WIDTH-1:0]   id_cnt_q,     id_cnt_d;
   logic [CPU_ID_WIDTH-1:0]     last_grant_q, last_grant_d;
   logic [PTR_WIDTH-1:0]        wptr_q [NUM_CPUS];
   logic [PTR_WIDTH-1:0]        wptr_d [NUM_CPUS];
   logic [PTR_WIDTH-1:0]        rptr_q [NUM_CPUS];
   logic [PTR_WIDTH-1:0]        rptr_d [NUM_CPUS];
   logic [CNT_WIDTH-1:0]        cnt_q  [NUM_CPUS];
   logic [CNT_WIDTH-1:0]        cnt_d  [NUM_CPUS];

   // FIFO storage; the CPU index is implied by which FIFO holds the entry
   logic [ADDR_WIDTH-1:0]       addr_mem_q [NUM_CPUS][FIFO_DEPTH];
   logic [BROAD_TYPE_WIDTH-1:0] type_mem_q [NUM_CPUS][FIFO_DEPTH];
   logic [BROAD_ID_WIDTH-1:0]   id_mem_q   [NUM_CPUS][FIFO_DEPTH];

   // Combinational
   logic [NUM_CPUS-1:0]         w_push;
   logic [NUM_CPUS-1:0]         w_pop;
   logic [NUM_CPUS-1:0]         w_empty;
   logic [ADDR_WIDTH-1:0]       w_addr     [NUM_CPUS];
   logic [BROAD_TYPE_WIDTH-1:0] w_type     [NUM_CPUS];
   logic [BROAD_ID_WIDTH-1:0]   w_new_id   [NUM_CPUS];
   logic                        w_grant_valid;
   logic [CPU_ID_WIDTH-1:0]     w_grant_idx;

   function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
      return (p == PTR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
   endfunction

   // Decode, acceptance and ID allocation. IDs are handed out in ascending
   // CPU order so simultaneous acceptances get consecutive values.
   always_comb begin
      logic [MBUS_CMD_WIDTH-1:0] cmd;
      logic                      is_wr;
      logic                      is_rd;
      logic [BROAD_ID_WIDTH-1:0] id_run;
      id_run = id_cnt_q;
      for (int k = 0; k < NUM_CPUS; k++) begin
         cmd         = mbus_cmd_array_i[k*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];
         is_wr       = (cmd == c_CMD_WR_BROAD);
         is_rd       = (cmd == c_CMD_RD_BROAD);
         w_addr[k]   = mbus_addr_array_i[k*ADDR_WIDTH +: ADDR_WIDTH];
         w_type[k]   = is_wr ? c_TYPE_WR : c_TYPE_RD;
         w_empty[k]  = (cnt_q[k] == '0);
         // The ack term blocks a second capture while the master still
         // holds the command during its ack cycle.
         w_push[k]   = (is_wr || is_rd) && (cnt_q[k] != CNT_WIDTH'(FIFO_DEPTH)) && !ack_q[k];
         w_new_id[k] = id_run;
         if (w_push[k]) begin
            id_run = id_run + BROAD_ID_WIDTH'(1);
         end
      end
      id_cnt_d = id_run;
   end

   // Round-robin arbiter: search starts just after the last granted index.
   always_comb begin
      logic [CPU_ID_WIDTH-1:0] idx;
      w_grant_valid = 1'b0;
      w_grant_idx   = '0;
      idx           = last_grant_q;
      for (int i = 0; i < NUM_CPUS; i++) begin
         idx = (idx == CPU_ID_WIDTH'(NUM_CPUS - 1)) ? '0 : idx + CPU_ID_WIDTH'(1);
         if (!w_grant_valid && !w_empty[idx] && !broad_fifo_status_full_i) begin
            w_grant_valid = 1'b1;
            w_grant_idx   = idx;
         end
      end
      last_grant_d = w_grant_valid ? w_grant_idx : last_grant_q;
   end

   // Pointer and occupancy next-state
   always_comb begin
      for (int k = 0; k < NUM_CPUS; k++) begin
         w_pop[k]  = w_grant_valid && (w_grant_idx == CPU_ID_WIDTH'(k));
         wptr_d[k] = w_push[k] ? ptr_inc(wptr_q[k]) : wptr_q[k];
         rptr_d[k] = w_pop[k]  ? ptr_inc(rptr_q[k]) : rptr_q[k];
         cnt_d[k]  = cnt_q[k];
         if (w_push[k] && !w_pop[k]) begin
            cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
         end else if (!w_push[k] && w_pop[k]) begin
            cnt_d[k] = cnt_q[k] - CNT_WIDTH'(1);
         end
      end
   end

   // First-word fall-through output of the granted head; zero when idle
   always_comb begin
      broad_fifo_wr_o = w_grant_valid;
      broad_addr_o    = '0;
      broad_type_o    = '0;
      broad_cpu_id_o  = '0;
      broad_id_o      = '0;
      if (w_grant_valid) begin
         broad_addr_o   = addr_mem_q[w_grant_idx][rptr_q[w_grant_idx]];
         broad_type_o   = type_mem_q[w_grant_idx][rptr_q[w_grant_idx]];
         broad_cpu_id_o = w_grant_idx;
         broad_id_o     = id_mem_q[w_grant_idx][rptr_q[w_grant_idx]];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ack_q        <= '0;
         id_cnt_q     <= '0;
         last_grant_q <= CPU_ID_WIDTH'(NUM_CPUS - 1);
         for (int k = 0; k < NUM_CPUS; k++) begin
            wptr_q[k] <= '0;
            rptr_q[k] <= '0;
            cnt_q[k]  <= '0;
         end
      end else begin
         ack_q        <= w_push;
         id_cnt_q     <= id_cnt_d;
         last_grant_q <= last_grant_d;
         for (int k = 0; k < NUM_CPUS; k++) begin
            wptr_q[k] <= wptr_d[k];
            rptr_q[k] <= rptr_d[k];
            cnt_q[k]  <= cnt_d[k];
         end
      end
   end

   // Storage needs no reset: entries are only visible through a non-zero count
   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_CPUS; k++) begin
         if (w_push[k]) begin
            addr_mem_q[k][wptr_q[k]] <= w_addr[k];
            type_mem_q[k][wptr_q[k]] <= w_type[k];
            id_mem_q[k][wptr_q[k]]   <= w_new_id[k];
         end
      end
   end

   assign mbus_ack_array_o = ack_q;

   for (genvar k = 0; k < NUM_CPUS; k++) begin : g_cnt_out
      assign fifo_count_array_o[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q[k];
   end

endmodule
`default_nettype wire

// File: tb/tb_mesi_isc_breq_fifos_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_mesi_isc_breq_fifos_n
// Description : Directed bench for mesi_isc_breq_fifos_n (4 CPUs, depth 3).
//               Expected broadcasts are queued as stimulus is issued and a
//               monitor compares them whenever the write strobe is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mesi_isc_breq_fifos_n;

   localparam int NC   = 4;
   localparam int CW   = 3;
   localparam int AW   = 32;
   localparam int TW   = 2;
   localparam int IW   = 7;
   localparam int FD   = 3;
   localparam int CIW  = 2;
   localparam int CNTW = 2;

   typedef struct packed {
      logic [AW-1:0]  addr;
      logic [TW-1:0]  typ;
      logic [CIW-1:0] cpu;
      logic [IW-1:0]  id;
   } ent_t;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                full_i = 1'b0;
   logic [CW-1:0]       cmd  [NC];
   logic [AW-1:0]       addr [NC];
   logic [NC*CW-1:0]    cmd_flat;
   logic [NC*AW-1:0]    addr_flat;
   logic [NC-1:0]       ack;
   logic                wr;
   logic [AW-1:0]       b_addr;
   logic [TW-1:0]       b_type;
   logic [CIW-1:0]      b_cpu;
   logic [IW-1:0]       b_id;
   logic [NC*CNTW-1:0]  cnt_flat;

   int   vectors     = 0;
   int   miscompares = 0;
   ent_t exp_q[$];
   ent_t mon_exp;
   ent_t mon_got;

   for (genvar k = 0; k < NC; k++) begin : g_pack
      assign cmd_flat[k*CW +: CW]  = cmd[k];
      assign addr_flat[k*AW +: AW] = addr[k];
   end

   mesi_isc_breq_fifos_n #(
      .NUM_CPUS(NC), .MBUS_CMD_WIDTH(CW), .ADDR_WIDTH(AW),
      .BROAD_TYPE_WIDTH(TW), .BROAD_ID_WIDTH(IW), .FIFO_DEPTH(FD)
   ) dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .mbus_cmd_array_i         (cmd_flat),
      .mbus_addr_array_i        (addr_flat),
      .broad_fifo_status_full_i (full_i),
      .mbus_ack_array_o         (ack),
      .broad_fifo_wr_o          (wr),
      .broad_addr_o             (b_addr),
      .broad_type_o             (b_type),
      .broad_cpu_id_o           (b_cpu),
      .broad_id_o               (b_id),
      .fifo_count_array_o       (cnt_flat)
   );

   always #5 clk = ~clk;

   // Monitor: every strobe must match the oldest expected broadcast
   always @(negedge clk) begin
      if (wr) begin
         vectors++;
         if (full_i) begin
            miscompares++;
            $display("FAIL wr_while_full: wr=%0b full=%0b", wr, full_i);
         end
         vectors++;
         mon_got = {b_addr, b_type, b_cpu, b_id};
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_broadcast: got addr=%h type=%0d cpu=%0d id=%0d, expected none",
                     b_addr, b_type, b_cpu, b_id);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               miscompares++;
               $display("FAIL broadcast: got addr=%h type=%0d cpu=%0d id=%0d, expected addr=%h type=%0d cpu=%0d id=%0d",
                        b_addr, b_type, b_cpu, b_id,
                        mon_exp.addr, mon_exp.typ, mon_exp.cpu, mon_exp.id);
            end
         end
      end else begin
         vectors++;
         if ({b_addr, b_type, b_cpu, b_id} !== '0) begin
            miscompares++;
            $display("FAIL idle_data: got addr=%h type=%0d cpu=%0d id=%0d, expected all 0",
                     b_addr, b_type, b_cpu, b_id);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
      end
   endtask

   task automatic push_exp(input logic [AW-1:0] a, input logic [TW-1:0] t,
                           input logic [CIW-1:0] c, input logic [IW-1:0] i);
      ent_t e;
      e = {a, t, c, i};
      exp_q.push_back(e);
   endtask

   task automatic clear_cmds();
      for (int k = 0; k < NC; k++) begin
         cmd[k]  = '0;
         addr[k] = '0;
      end
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      full_i = 1'b0;
      clear_cmds();
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
         cyc();
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain_timeout: got %0d pending broadcasts expected 0", exp_q.size());
         exp_q.delete();
      end
      cyc();
   endtask

   function automatic logic [CNTW-1:0] cnt_of(input int k);
      return cnt_flat[k*CNTW +: CNTW];
   endfunction

   initial begin
      logic exp_ack [8];
      exp_ack = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      clear_cmds();

      // Reset state
      rst_n = 1'b0;
      cyc();
      cyc();
      @(negedge clk);
      chk("reset_ack",   64'(ack),      64'h0);
      chk("reset_wr",    64'(wr),       64'h0);
      chk("reset_count", 64'(cnt_flat), 64'h0);
      rst_n = 1'b1;

      // Single request and ID sequencing
      cyc();
      cmd[2] = 3'd4; addr[2] = 32'h1000;
      push_exp(32'h1000, 2'd2, 2'd2, 7'd0);
      cyc();
      cmd[2] = 3'd0;
      @(negedge clk);
      chk("single_ack",   64'(ack),       64'h4);
      chk("single_count", 64'(cnt_of(2)), 64'h1);
      cyc();
      @(negedge clk);
      chk("single_ack_low", 64'(ack),     64'h0);
      chk("single_drained", 64'(cnt_flat), 64'h0);
      cyc();
      cmd[2] = 3'd4; addr[2] = 32'h1004;
      push_exp(32'h1004, 2'd2, 2'd2, 7'd1);
      cyc();
      cmd[2] = 3'd0;
      wait_drain(10);

      // Simultaneous acceptance and ordered draining
      do_reset();
      for (int k = 0; k < NC; k++) begin
         cmd[k]  = 3'd3;
         addr[k] = 32'h2000 + 32'(k * 16);
         push_exp(32'h2000 + 32'(k * 16), 2'd1, 2'(k), 7'(k));
      end
      cyc();
      clear_cmds();
      @(negedge clk);
      chk("all_ack", 64'(ack), 64'hF);
      chk("all_wr0", 64'(wr),  64'h1);
      for (int j = 1; j < 4; j++) begin
         cyc();
         @(negedge clk);
         chk("all_wr_consecutive", 64'(wr), 64'h1);
      end
      wait_drain(10);

      // Round-robin fairness between CPUs 0 and 1 with both FIFOs full
      do_reset();
      full_i = 1'b1;
      cmd[0] = 3'd3; addr[0] = 32'h3000;
      cmd[1] = 3'd3; addr[1] = 32'h3100;
      for (int j = 0; j < 3; j++) begin
         push_exp(32'h3000, 2'd1, 2'd0, 7'(2 * j));
         push_exp(32'h3100, 2'd1, 2'd1, 7'(2 * j + 1));
      end
      for (int j = 0; j < 6; j++) begin
         cyc();
      end
      clear_cmds();
      @(negedge clk);
      chk("rr_count01", 64'(cnt_flat), 64'h0F);
      cyc();
      full_i = 1'b0;
      wait_drain(12);

      // Backpressure: CPU 1 fills its FIFO, then the held command waits
      do_reset();
      full_i = 1'b1;
      cmd[1] = 3'd3; addr[1] = 32'h4000;
      for (int j = 0; j < 8; j++) begin
         cyc();
         @(negedge clk);
         chk("bp_ack_seq", 64'(ack[1]), 64'(exp_ack[j]));
      end
      chk("bp_count_full", 64'(cnt_of(1)), 64'h3);
      for (int j = 0; j < 4; j++) begin
         push_exp(32'h4000, 2'd1, 2'd1, 7'(j));
      end
      cyc();
      full_i = 1'b0;
      cyc();
      cyc();
      cmd[1] = 3'd0;
      @(negedge clk);
      chk("bp_held_accept", 64'(ack[1]), 64'h1);
      wait_drain(12);

      // Ignored commands
      do_reset();
      for (int c = 0; c < 8; c++) begin
         if (c != 3 && c != 4) begin
            for (int k = 0; k < NC; k++) begin
               cmd[k]  = 3'(c);
               addr[k] = 32'h5500;
            end
            cyc();
            @(negedge clk);
            chk("ignored_ack", 64'(ack), 64'h0);
            cyc();
            @(negedge clk);
            chk("ignored_count", 64'(cnt_flat), 64'h0);
         end
      end
      clear_cmds();

      // ID wrap across 130 broadcasts
      for (int i = 0; i < 130; i++) begin
         cyc();
         cmd[0] = 3'd3; addr[0] = 32'h5000 + 32'(i);
         push_exp(32'h5000 + 32'(i), 2'd1, 2'd0, 7'(i));
         cyc();
         cmd[0] = 3'd0;
      end
      wait_drain(10);

      // Reset mid-operation with two entries queued and acks high
      do_reset();
      full_i = 1'b1;
      cmd[0] = 3'd3; addr[0] = 32'h6000;
      cmd[3] = 3'd4; addr[3] = 32'h6300;
      cyc();
      clear_cmds();
      @(negedge clk);
      chk("mid_ack_before", 64'(ack),      64'h9);
      chk("mid_count_before", 64'(cnt_flat), 64'h41);
      rst_n = 1'b0;
      cyc();
      @(negedge clk);
      chk("mid_ack_after",   64'(ack),      64'h0);
      chk("mid_count_after", 64'(cnt_flat), 64'h0);
      chk("mid_wr_after",    64'(wr),       64'h0);
      cyc();
      rst_n  = 1'b1;
      full_i = 1'b0;
      cyc();
      @(negedge clk);
      chk("mid_discarded_wr", 64'(wr), 64'h0);
      cyc();
      cmd[0] = 3'd3; addr[0] = 32'h6010;
      cmd[3] = 3'd3; addr[3] = 32'h6310;
      push_exp(32'h6010, 2'd1, 2'd0, 7'd0);
      push_exp(32'h6310, 2'd1, 2'd3, 7'd1);
      cyc();
      clear_cmds();
      @(negedge clk);
      chk("post_reset_ack", 64'(ack), 64'h9);
      wait_drain(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
